axi4_wr_slave_mem: RTL and testbench
====================================

Name: axi4_wr_slave_mem

Overview:
AXI4 write-channel responder (slave end) backed by a byte-addressable internal memory. It accepts AW and W bursts, applies WSTRB byte enables and returns a B response. It sits opposite the VIP master on the AW/W/B channels of axi_intf and acts as the reference write target for write-path tests. A registered debug read port gives the scoreboard direct visibility of memory contents.

Parameters:
ADDR_WIDTH, 16, byte address width (matches `ADDR_WIDTH)
DATA_WIDTH, 32, data bus width in bits; power of two, 8..128 (matches `DATA_WIDTH)
MEM_DEPTH, 256, memory depth in DATA_WIDTH words

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
AWID  in  8  write address ID
AWADDR  in  ADDR_WIDTH  burst start byte address
AWLEN  in  8  beats minus 1
AWSIZE  in  3  log2(bytes per beat)
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
AWVALID  in  1  address valid
AWREADY  out  1  address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte lane enables
WLAST  in  1  last beat
WVALID  in  1  data valid
WREADY  out  1  data ready
BID  out  8  response ID
BRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
BVALID  out  1  response valid
BREADY  in  1  response ready
dbg_raddr  in  log2(MEM_DEPTH)  debug word address
dbg_rdata  out  DATA_WIDTH  debug read data, registered

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=00, dbg_rdata=0, FSM=IDLE. Memory contents are not reset.
- Reset mid-burst: the burst is abandoned and beats already written remain. No B response is issued.
- FSM has three states: IDLE, DATA, RESP. Only one burst is outstanding.
- IDLE:
  - AWREADY=1 from the first clk edge after reset deasserts.
  - On AWVALID&&AWREADY, latch ID, ADDR, LEN, SIZE and BURST, clear the error flags and beat counter, then go to DATA. AWREADY drops in the next cycle.
  - WREADY=0 in IDLE. W data presented before AW is held off, not dropped.
- DATA:
  - WREADY=1 from the cycle after the AW handshake (first W accept at the earliest on AW-cycle+1).
  - Each WVALID&&WREADY beat writes the byte lanes selected by WSTRB to word (addr >> log2(DATA_WIDTH/8)). The beat counter then increments.
  - Address update: FIXED keeps the address. INCR uses addr = (addr aligned to size) + 2^SIZE. WRAP is the same as INCR but wraps within a (LEN+1)*2^SIZE aligned window.
  - An unaligned INCR start is honoured for beat 0 only, via WSTRB as supplied.
  - On the accepted beat with WLAST=1, go to RESP. The burst ends only on WLAST.
- Error rules:
  - All error flags are sticky for the whole burst.
  - SLVERR, and no memory writes for the burst: AWBURST=11; AWSIZE > log2(DATA_WIDTH/8); WRAP with LEN not in {1,3,7,15}.
  - SLVERR, with in-range beats still written: WLAST seen at beat count != LEN; beats beyond LEN are discarded and not written.
  - DECERR: any beat whose word index >= MEM_DEPTH. That beat is not written; other in-range beats are.
  - Priority: DECERR over SLVERR over OKAY.
- RESP:
  - BVALID=1 in the cycle after the last W handshake, with BID = latched AWID and BRESP per the error rules. WREADY=0.
  - BID and BRESP stay stable while BVALID=1 and BREADY=0.
  - On BVALID&&BREADY, go to IDLE. BVALID=0 and AWREADY=1 in the next cycle.
  - Minimum spacing is 1 idle cycle between the B handshake and the next AW accept.
- Debug port: dbg_rdata = mem[dbg_raddr], registered, 1-cycle latency. A write and a debug read to the same word in the same cycle returns the old data.

Test Plan:
- INCR, DATA_WIDTH=32: AWADDR=0x10, AWLEN=3, AWSIZE=2, AWID=0x5A, WDATA 0x11111111..0x44444444, WSTRB=F -> words 4..7 hold the data; BID=0x5A, BRESP=00, BVALID in the cycle after WLAST.
- WRAP: AWADDR=0x18, AWLEN=3, SIZE=2 -> beats land at words 6,7,4,5; BRESP=00. FIXED: AWADDR=0x20, AWLEN=2 -> only word 8 written, final value = beat 2.
- Strobes: word 0 preset to 0xFFFFFFFF, single beat WDATA=0, WSTRB=0101 -> word 0 reads 0xFF00FF00 via the debug port one cycle after dbg_raddr=0.
- Errors: AWBURST=11 -> SLVERR, memory unchanged. AWADDR=0x3FC, LEN=1 -> word 255 written, beat 1 DECERR dropped, BRESP=11. WLAST on beat 1 of LEN=3 -> BRESP=10.
- Backpressure: hold BREADY=0 for 5 cycles -> BVALID, BID and BRESP stable, AWREADY stays 0. WVALID raised before AWVALID -> WREADY stays 0 until the cycle after the AW handshake.
- Reset during DATA after 2 of 4 beats -> outputs return to their reset values immediately, 2 words written, no B response, and the next burst completes normally.

Source files
------------

// File: rtl/axi4_wr_slave_mem_if.sv
// AXI4 write-channel bundle (AW, W, B) between a write master and axi4_wr_slave_mem.
interface axi4_wr_slave_mem_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [7:0]              AWID;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;
  logic [7:0]              BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WDATA, WSTRB, WLAST, WVALID, BREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID
  );
endinterface

// File: rtl/axi4_wr_slave_mem.sv
// AXI4 write responder over a byte-enabled word memory, one burst outstanding,
// with a registered debug read port for scoreboards.
module axi4_wr_slave_mem #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  axi4_wr_slave_mem_if.slave           bus,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_raddr,
  output logic [DATA_WIDTH-1:0]        dbg_rdata
);
  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int LANE_LG = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam logic [2:0]            MAX_SIZE = 3'(LANE_LG);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1'b1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_awready;
  logic                    r_wready;
  logic                    r_bvalid;
  logic [7:0]              r_bid;
  logic [1:0]              r_bresp;
  logic [7:0]              r_id;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_len;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;
  logic [7:0]              r_cnt;
  logic                    r_over;
  logic                    r_cfg_err;
  logic                    r_slverr;
  logic                    r_decerr;
  logic [DATA_WIDTH-1:0]   r_dbg_rdata;
  logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

  logic                    w_whs;
  logic                    w_in_range;
  logic                    w_wr_en;
  logic                    w_beat_dec;
  logic                    w_last_err;
  logic                    w_decerr_nxt;
  logic                    w_slverr_nxt;
  logic                    w_aw_cfg_err;
  logic [ADDR_WIDTH-1:0]   w_word;
  logic [ADDR_WIDTH-1:0]   w_bytes;
  logic [ADDR_WIDTH-1:0]   w_aligned;
  logic [ADDR_WIDTH-1:0]   w_incr;
  logic [ADDR_WIDTH-1:0]   w_wrap_mask;
  logic [ADDR_WIDTH-1:0]   w_next_addr;

  // Beat qualification, error detection and next-beat address generation.
  always_comb begin
    w_whs        = bus.WVALID && r_wready;
    w_word       = r_addr >> LANE_LG;
    w_in_range   = (w_word < DEPTH_A);
    // r_over marks beats past LEN: they are swallowed without writing or DECERR.
    w_wr_en      = w_whs && !r_cfg_err && !r_over && w_in_range;
    w_beat_dec   = w_whs && !r_over && !w_in_range;
    w_last_err   = bus.WLAST && (r_over || (r_cnt != r_len));
    w_decerr_nxt = r_decerr || w_beat_dec;
    w_slverr_nxt = r_slverr || w_last_err;
    w_bytes      = ONE_A << r_size;
    w_aligned    = r_addr & ~(w_bytes - ONE_A);
    w_incr       = w_aligned + w_bytes;
    w_wrap_mask  = ((ADDR_WIDTH'(r_len) + ONE_A) << r_size) - ONE_A;
    case (r_burst)
      2'b00:   w_next_addr = r_addr;
      2'b10:   w_next_addr = (r_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
      default: w_next_addr = w_incr;
    endcase
    w_aw_cfg_err = (bus.AWBURST == 2'b11) || (bus.AWSIZE > MAX_SIZE) ||
                   ((bus.AWBURST == 2'b10) &&
                    !((bus.AWLEN == 8'd1) || (bus.AWLEN == 8'd3) ||
                      (bus.AWLEN == 8'd7) || (bus.AWLEN == 8'd15)));
  end

  // Burst FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= 8'h00;
      r_bresp   <= 2'b00;
      r_id      <= 8'h00;
      r_addr    <= {ADDR_WIDTH{1'b0}};
      r_len     <= 8'h00;
      r_size    <= 3'd0;
      r_burst   <= 2'b00;
      r_cnt     <= 8'h00;
      r_over    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_slverr  <= 1'b0;
      r_decerr  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.AWVALID && r_awready) begin
            r_id      <= bus.AWID;
            r_addr    <= bus.AWADDR;
            r_len     <= bus.AWLEN;
            r_size    <= bus.AWSIZE;
            r_burst   <= bus.AWBURST;
            r_cnt     <= 8'h00;
            r_over    <= 1'b0;
            r_cfg_err <= w_aw_cfg_err;
            r_slverr  <= w_aw_cfg_err;
            r_decerr  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_state   <= DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        DATA: begin
          if (w_whs) begin
            r_cnt    <= r_cnt + 8'd1;
            r_addr   <= w_next_addr;
            r_decerr <= w_decerr_nxt;
            if (r_cnt == r_len) begin
              r_over <= 1'b1;
            end
            if (bus.WLAST) begin
              r_slverr <= w_slverr_nxt;
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_bresp  <= w_decerr_nxt ? 2'b11 : (w_slverr_nxt ? 2'b10 : 2'b00);
              r_state  <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane memory write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (bus.WSTRB[i]) begin
          r_mem[w_word[IDX_W-1:0]][i*8 +: 8] <= bus.WDATA[i*8 +: 8];
        end
      end
    end
  end

  // Debug read port; a same-cycle write to the same word returns the old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dbg_rdata <= {DATA_WIDTH{1'b0}};
    end else begin
      r_dbg_rdata <= r_mem[dbg_raddr];
    end
  end

  assign bus.AWREADY = r_awready;
  assign bus.WREADY  = r_wready;
  assign bus.BVALID  = r_bvalid;
  assign bus.BID     = r_bid;
  assign bus.BRESP   = r_bresp;
  assign dbg_rdata   = r_dbg_rdata;
endmodule

// File: tb/tb_axi4_wr_slave_mem.sv
// Directed, table-driven bench for axi4_wr_slave_mem (DATA_WIDTH=32, MEM_DEPTH=256).
module tb_axi4_wr_slave_mem;
  logic        clk;
  logic        reset;
  logic [7:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  int          n_checks;
  int          n_fail;

  axi4_wr_slave_mem_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  axi4_wr_slave_mem #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0]  id;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          nbeats;
    logic [31:0] data0;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    int          w1;
    logic [31:0] v1;
    int          w2;
    logic [31:0] v2;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok = 1'b0;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst;
    bus.AWVALID = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.AWREADY) ok = 1'b1;
      tick();
    end
    bus.AWVALID = 1'b0;
    check("aw_handshake", {31'd0, ok}, 32'd1);
    check("awready_drop", {31'd0, bus.AWREADY}, 32'd0);
    check("wready_after_aw", {31'd0, bus.WREADY}, 32'd1);
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    bit ok = 1'b0;
    bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.WREADY) ok = 1'b1;
      tick();
    end
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
    check("w_handshake", {31'd0, ok}, 32'd1);
  endtask

  task automatic b_take(input logic [7:0] exp_id, input logic [1:0] exp_resp);
    check("bvalid_after_wlast", {31'd0, bus.BVALID}, 32'd1);
    check("wready_in_resp", {31'd0, bus.WREADY}, 32'd0);
    check("bid", {24'd0, bus.BID}, {24'd0, exp_id});
    check("bresp", {30'd0, bus.BRESP}, {30'd0, exp_resp});
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    check("bvalid_clear", {31'd0, bus.BVALID}, 32'd0);
    check("awready_after_b", {31'd0, bus.AWREADY}, 32'd1);
  endtask

  task automatic dbg_check(input string name, input int word, input logic [31:0] exp);
    dbg_raddr = word[7:0];
    tick();
    check(name, dbg_rdata, exp);
  endtask

  task automatic run_vec(input vec_t v);
    aw_send(v.id, v.addr, v.len, v.size, v.burst);
    for (int k = 0; k < v.nbeats; k++) begin
      w_beat(v.data0 * 32'(k + 1), v.strb, (k == v.nbeats - 1));
    end
    b_take(v.id, v.exp_resp);
    dbg_check("mem_word_a", v.w1, v.v1);
    dbg_check("mem_word_b", v.w2, v.v2);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //           id     addr      len    sz    burst  nb  data0          strb   resp   w1   v1             w2   v2
    vecs[0]  = '{8'h5A, 16'h0010, 8'd3, 3'd2, 2'b01, 4, 32'h11111111, 4'hF, 2'b00, 7,   32'h44444444, 4,   32'h11111111};
    vecs[1]  = '{8'h01, 16'h0018, 8'd3, 3'd2, 2'b10, 4, 32'h11111111, 4'hF, 2'b00, 4,   32'h33333333, 5,   32'h44444444};
    vecs[2]  = '{8'h02, 16'h0020, 8'd2, 3'd2, 2'b00, 3, 32'h01010101, 4'hF, 2'b00, 8,   32'h03030303, 6,   32'h11111111};
    vecs[3]  = '{8'h03, 16'h0040, 8'd1, 3'd2, 2'b01, 2, 32'hA5A5A5A5, 4'hF, 2'b00, 16,  32'hA5A5A5A5, 17,  32'h4B4B4B4A};
    vecs[4]  = '{8'h04, 16'h0040, 8'd1, 3'd2, 2'b11, 2, 32'h12345678, 4'hF, 2'b10, 16,  32'hA5A5A5A5, 17,  32'h4B4B4B4A};
    vecs[5]  = '{8'h05, 16'h0040, 8'd1, 3'd3, 2'b01, 2, 32'h12345678, 4'hF, 2'b10, 16,  32'hA5A5A5A5, 17,  32'h4B4B4B4A};
    vecs[6]  = '{8'h06, 16'h0040, 8'd2, 3'd2, 2'b10, 3, 32'h12345678, 4'hF, 2'b10, 16,  32'hA5A5A5A5, 17,  32'h4B4B4B4A};
    vecs[7]  = '{8'h07, 16'h0000, 8'd0, 3'd2, 2'b01, 1, 32'hFFFFFFFF, 4'hF, 2'b00, 0,   32'hFFFFFFFF, 16,  32'hA5A5A5A5};
    vecs[8]  = '{8'h08, 16'h03FC, 8'd1, 3'd2, 2'b01, 2, 32'h77777777, 4'hF, 2'b11, 255, 32'h77777777, 0,   32'hFFFFFFFF};
    vecs[9]  = '{8'h09, 16'h0000, 8'd0, 3'd2, 2'b01, 1, 32'h00000000, 4'h5, 2'b00, 0,   32'hFF00FF00, 255, 32'h77777777};
    vecs[10] = '{8'h0A, 16'h0060, 8'd3, 3'd2, 2'b01, 2, 32'h0A0A0A0A, 4'hF, 2'b10, 24,  32'h0A0A0A0A, 25,  32'h14141414};
    vecs[11] = '{8'h0B, 16'h0084, 8'd0, 3'd2, 2'b01, 1, 32'h3C3C3C3C, 4'hF, 2'b00, 33,  32'h3C3C3C3C, 25,  32'h14141414};
    vecs[12] = '{8'h0C, 16'h0080, 8'd0, 3'd2, 2'b01, 2, 32'h0B0B0B0B, 4'hF, 2'b10, 32,  32'h0B0B0B0B, 33,  32'h3C3C3C3C};
    vecs[13] = '{8'h0D, 16'h03FC, 8'd1, 3'd2, 2'b01, 3, 32'h01020304, 4'hF, 2'b11, 255, 32'h01020304, 0,   32'hFF00FF00};

    reset = 1'b1;
    dbg_raddr = 8'd0;
    bus.AWID = 8'h00; bus.AWADDR = 16'h0000; bus.AWLEN = 8'd0; bus.AWSIZE = 3'd0;
    bus.AWBURST = 2'b00; bus.AWVALID = 1'b0;
    bus.WDATA = 32'h0; bus.WSTRB = 4'h0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0;

    #2;
    check("rst_awready", {31'd0, bus.AWREADY}, 32'd0);
    check("rst_wready", {31'd0, bus.WREADY}, 32'd0);
    check("rst_bvalid", {31'd0, bus.BVALID}, 32'd0);
    check("rst_bid", {24'd0, bus.BID}, 32'd0);
    check("rst_bresp", {30'd0, bus.BRESP}, 32'd0);
    check("rst_dbg", dbg_rdata, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    check("awready_pre_edge", {31'd0, bus.AWREADY}, 32'd0);
    tick();
    check("awready_post_reset", {31'd0, bus.AWREADY}, 32'd1);

    for (int v = 0; v < 14; v++) begin
      run_vec(vecs[v]);
    end

    // W ahead of AW, with a same-cycle debug read of the word being written.
    dbg_raddr = 8'd4;
    bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'hF; bus.WLAST = 1'b1; bus.WVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wready_held_off", {31'd0, bus.WREADY}, 32'd0);
    end
    aw_send(8'h22, 16'h0010, 8'd0, 3'd2, 2'b01);
    tick();
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
    check("dbg_old_data", dbg_rdata, 32'h33333333);
    b_take(8'h22, 2'b00);
    dbg_check("dbg_new_data", 4, 32'hCAFEF00D);

    // B backpressure: response held stable, no new AW accepted.
    aw_send(8'h6C, 16'h0100, 8'd0, 3'd2, 2'b01);
    w_beat(32'h5555AAAA, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", {31'd0, bus.BVALID}, 32'd1);
      check("bp_bid", {24'd0, bus.BID}, 32'h6C);
      check("bp_bresp", {30'd0, bus.BRESP}, 32'd0);
      check("bp_awready", {31'd0, bus.AWREADY}, 32'd0);
      tick();
    end
    b_take(8'h6C, 2'b00);
    dbg_check("bp_word", 64, 32'h5555AAAA);

    // Reset after 2 of 4 beats.
    aw_send(8'h33, 16'h00C0, 8'd3, 3'd2, 2'b01);
    w_beat(32'hB0B0B0B0, 4'hF, 1'b0);
    w_beat(32'hB1B1B1B1, 4'hF, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_awready", {31'd0, bus.AWREADY}, 32'd0);
    check("mid_rst_wready", {31'd0, bus.WREADY}, 32'd0);
    check("mid_rst_bvalid", {31'd0, bus.BVALID}, 32'd0);
    check("mid_rst_bid", {24'd0, bus.BID}, 32'd0);
    check("mid_rst_dbg", dbg_rdata, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_b_after_rst", {31'd0, bus.BVALID}, 32'd0);
    end
    dbg_check("rst_beat0", 48, 32'hB0B0B0B0);
    dbg_check("rst_beat1", 49, 32'hB1B1B1B1);
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
